rgb_pwm_driver: RTL and testbench
=================================

Name: rgb_pwm_driver

Overview:
- Consumes the 24-bit `light` colour word produced by the lights selector.
- Converts it into three 8-bit-resolution PWM outputs that drive the physical red, green and blue LED pins.
- A shadow register captures each new colour. The active duty cycles change only on a PWM frame boundary, so the LEDs never glitch mid-frame.
- Sits between the lights selector and the board top level.

Parameters:
- PRESCALE, default 4: clock cycles per PWM tick. Legal range is 1..65535.
- PRE_W, default 16: width of the prescale counter. Must satisfy 2^PRE_W > PRESCALE.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- enable  input  1  1 runs the PWM; 0 pauses the counters and forces the outputs low.
- colour  input  24  colour word: [23:16]=R, [15:8]=G, [7:0]=B. 24'h0000FF is pure blue.
- load  input  1  sampled each clock; when high, `colour` is captured into the shadow register.
- pwm_r  output  1  red PWM, registered.
- pwm_g  output  1  green PWM, registered.
- pwm_b  output  1  blue PWM, registered.
- frame_start  output  1  one-cycle pulse at the start of each PWM frame.
- pending  output  1  high while a shadow colour is waiting for the next frame boundary.

Behaviour:
- Reset (rst low, asynchronous): the following all go to 0 immediately, regardless of clk:
  - prescale count `pre`, PWM count `cnt`
  - `shadow[23:0]`, `active[23:0]`
  - `pending`
  - `pwm_r`, `pwm_g`, `pwm_b`, `frame_start`
- Reset applied mid-frame discards any pending colour.
- Prescaler, while enable=1:
  - `pre` counts 0..PRESCALE-1 and wraps.
  - `tick` = enable && (pre == PRESCALE-1).
  - With PRESCALE=1, `tick` = enable every cycle.
- PWM counter: 8-bit `cnt` increments on `tick` and wraps 255 -> 0.
  - A frame is 256 ticks = 256*PRESCALE clocks.
  - `wrap` = tick && (cnt == 255).
- Load path, with `load` taking priority over the boundary clear:
  - If load=1 and wrap=1 in the same cycle: `active` <= colour, `shadow` <= colour, `pending` <= 0. The new colour applies to the frame that starts next.
  - If load=1 and wrap=0: `shadow` <= colour, `pending` <= 1. Several loads within one frame: the last one wins.
  - If load=0, wrap=1 and pending=1: `active` <= shadow, `pending` <= 0.
  - If load=0, wrap=1 and pending=0: `active` holds.
- PWM outputs are registered:
  - `pwm_x` <= enable && (cnt < active_x), using the current cycle's `cnt` and `active`. The output therefore lags `cnt` by one clock.
  - Duty 0 -> the output is never high.
  - Duty 255 -> the output is high for 255 of 256 ticks.
  - Full-on is not reachable by design.
- `frame_start` is registered: `frame_start` <= wrap. It is high for exactly one clock, coincident with the first cycle of `cnt` = 0 in the new frame.
  - The first frame after reset produces no `frame_start`.
- Enable low:
  - `pre` and `cnt` hold.
  - `pwm_r`, `pwm_g` and `pwm_b` go 0 at the next edge.
  - `frame_start` stays 0.
  - `load` still updates `shadow` and sets `pending`.
  - `active` is not updated, since there is no wrap.
- Re-enable: counting resumes from the held `pre`/`cnt`, and outputs follow the compare from the next edge.
- All arithmetic is unsigned. The compare is an 8-bit magnitude compare.

Test Plan:
1. Reset: PRESCALE=1, run mid-frame with active=24'h808080, pull rst low between clock edges -> all outputs 0 before the next edge. After release, `cnt` restarts at 0 and `pending`=0.
2. Blue load: PRESCALE=1, enable=1, load 24'h0000FF for 1 cycle at cnt=10 -> `pending`=1 until wrap. From the frame after `frame_start`, pwm_b is high for 255 consecutive clocks and low for 1; pwm_r and pwm_g stay 0.
3. Mixed duty with PRESCALE=4: load 24'h804000 -> per 1024-clock frame, pwm_r high for 512 clocks, pwm_g high for 256 clocks, pwm_b 0. No change is visible before `frame_start`.
4. Double load in one frame: load 24'hFF0000, then load 24'h00FF00 -> the next frame shows only pwm_g active (255/256). `pending` clears on wrap.
5. Load coincident with wrap (cnt=255, tick=1): load 24'hFFFFFF -> `pending` stays 0, and the new frame immediately shows all three outputs high for 255/256 ticks.
6. Enable toggle: deassert enable at cnt=100 for 20 clocks, with a load occurring during the pause -> outputs 0 within 1 clock and `cnt` holds at 100. After re-enable, counting resumes at 100, and the loaded colour applies at the next wrap.

Source files
------------

// File: rtl/rgb_pwm_driver.sv
// ---------------------------------------------------------------------------
// rgb_pwm_driver
//
// Purpose:
//   Turns a 24-bit colour word into three 8-bit PWM outputs for the red,
//   green and blue LED pins. A prescaler divides clk into PWM ticks. An
//   8-bit tick counter defines a 256-tick frame.
//
//   New colours are captured into a shadow register first. They are copied
//   into the active duty registers only on a frame boundary (wrap). This
//   stops an LED from glitching part-way through a frame.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous reset, active low
//   enable       in   1 = run the PWM; 0 = hold the counters, outputs low
//   colour[23:0] in   [23:16]=R, [15:8]=G, [7:0]=B
//   load         in   capture colour into the shadow register this cycle
//   pwm_r        out  red PWM (registered)
//   pwm_g        out  green PWM (registered)
//   pwm_b        out  blue PWM (registered)
//   frame_start  out  one-cycle pulse in the first clock of each new frame
//   pending      out  a shadow colour is waiting for the next frame boundary
//
// Parameters:
//   PRESCALE     clocks per PWM tick, 1..65535
//   PRE_W        prescale counter width, 2**PRE_W > PRESCALE
// ---------------------------------------------------------------------------
module rgb_pwm_driver #(
    parameter int unsigned PRESCALE = 4,
    parameter int unsigned PRE_W    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [23:0] colour,
    input  logic        load,
    output logic        pwm_r,
    output logic        pwm_g,
    output logic        pwm_b,
    output logic        frame_start,
    output logic        pending
);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] pre;
    logic [7:0]       cnt;
    logic [23:0]      shadow;
    logic [23:0]      active;
    logic             tick;
    logic             wrap;

    // With PRESCALE == 1, PRE_LAST is 0 and pre stays at 0.
    // In that case tick follows enable every cycle.
    assign tick = enable && (pre == PRE_LAST);
    assign wrap = tick && (cnt == 8'hFF);

    // Prescaler: counts only while enabled, so a pause resumes mid-tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre <= '0;
        end else if (enable) begin
            if (tick) begin
                pre <= '0;
            end else begin
                pre <= pre + PRE_W'(1);
            end
        end
    end

    // PWM tick counter. It is 8 bits wide, so 255 -> 0 is the natural wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= 8'h00;
        end else if (tick) begin
            cnt <= cnt + 8'h01;
        end
    end

    // Shadow / active colour registers.
    // A load always wins over the boundary copy.
    // A load that lands exactly on the wrap goes straight into active,
    // so pending never rises for it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow  <= 24'h000000;
            active  <= 24'h000000;
            pending <= 1'b0;
        end else if (load) begin
            shadow <= colour;
            if (wrap) begin
                active  <= colour;
                pending <= 1'b0;
            end else begin
                pending <= 1'b1;
            end
        end else if (wrap && pending) begin
            active  <= shadow;
            pending <= 1'b0;
        end
    end

    // Registered outputs.
    // Each compare uses this cycle's cnt and active, so the pins lag cnt
    // by one clock. Because the compare is strict, a duty of 255 still
    // leaves one low tick per frame.
    // frame_start therefore lines up with the first clock of cnt == 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_r       <= 1'b0;
            pwm_g       <= 1'b0;
            pwm_b       <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pwm_r       <= enable && (cnt < active[23:16]);
            pwm_g       <= enable && (cnt < active[15:8]);
            pwm_b       <= enable && (cnt < active[7:0]);
            frame_start <= wrap;
        end
    end

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// ---------------------------------------------------------------------------
// tb_rgb_pwm_driver
//
// Two DUTs (PRESCALE=1 and PRESCALE=4) receive the same stimulus.
// Each DUT has a reference model that tracks only:
//   - the number of enabled clocks since reset
//   - the shadow/active colours
// tick, cnt and wrap are derived from the enabled-clock count with
// division and modulo.
// Directed scenarios run first, followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_rgb_pwm_driver;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        load;
    logic [23:0] colour;
    logic [4:0]  o0;    // {pwm_r, pwm_g, pwm_b, frame_start, pending}
    logic [4:0]  o1;

    int n_total = 0;
    int n_bad   = 0;

    // reference model state, index 0 -> PRESCALE 1, index 1 -> PRESCALE 4
    int          nen [2];
    logic [23:0] msh [2];
    logic [23:0] mact[2];
    bit          mpend[2];
    logic [4:0]  exp_o[2];
    int          acc [2][3];
    int          lf  [2][3];

    rgb_pwm_driver #(.PRESCALE(1), .PRE_W(16)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .colour(colour), .load(load),
        .pwm_r(o0[4]), .pwm_g(o0[3]), .pwm_b(o0[2]),
        .frame_start(o0[1]), .pending(o0[0])
    );

    rgb_pwm_driver #(.PRESCALE(4), .PRE_W(16)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .colour(colour), .load(load),
        .pwm_r(o1[4]), .pwm_g(o1[3]), .pwm_b(o1[2]),
        .frame_start(o1[1]), .pending(o1[0])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int getp(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic int mcnt(input int i);
        return (nen[i] / getp(i)) % 256;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            nen[i]   = 0;
            msh[i]   = '0;
            mact[i]  = '0;
            mpend[i] = 1'b0;
            exp_o[i] = '0;
            for (int c = 0; c < 3; c++) begin
                acc[i][c] = 0;
                lf[i][c]  = -1;
            end
        end
    endtask

    // Predicts the outputs after the coming clock edge,
    // using the inputs applied for that edge.
    task automatic model_step(input int i, input bit en, input bit ld, input logic [23:0] col);
        int p;
        int c;
        bit tk;
        bit wr;
        bit r;
        bit g;
        bit b;
        p  = getp(i);
        c  = (nen[i] / p) % 256;
        tk = en && ((nen[i] % p) == p - 1);
        wr = tk && (c == 255);
        r  = en && (c < int'(mact[i][23:16]));
        g  = en && (c < int'(mact[i][15:8]));
        b  = en && (c < int'(mact[i][7:0]));
        if (ld) begin
            msh[i] = col;
            if (wr) begin
                mact[i]  = col;
                mpend[i] = 1'b0;
            end else begin
                mpend[i] = 1'b1;
            end
        end else if (wr && mpend[i]) begin
            mact[i]  = msh[i];
            mpend[i] = 1'b0;
        end
        if (en) nen[i]++;
        exp_o[i] = {r, g, b, wr, mpend[i]};
    endtask

    task automatic check_cycle();
        logic [4:0] obs;
        logic [7:0] dcnt;
        for (int i = 0; i < 2; i++) begin
            obs  = (i == 0) ? o0 : o1;
            dcnt = (i == 0) ? dut0.cnt : dut1.cnt;
            chk_eq($sformatf("outs_p%0d", getp(i)), 32'(obs), 32'(exp_o[i]));
            chk_eq($sformatf("cnt_p%0d", getp(i)), 32'(dcnt), 32'(mcnt(i)));
            if (exp_o[i][1]) begin
                for (int c = 0; c < 3; c++) begin
                    lf[i][c]  = acc[i][c];
                    acc[i][c] = 0;
                end
            end
            for (int c = 0; c < 3; c++) acc[i][c] += int'(obs[4-c]);
        end
    endtask

    task automatic step(input bit en, input bit ld, input logic [23:0] col);
        enable = en;
        load   = ld;
        colour = col;
        for (int i = 0; i < 2; i++) model_step(i, en, ld, col);
        @(negedge clk);
        check_cycle();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 24'h0);
    endtask

    task automatic chk_frame(input string tag, input int i, input int r, input int g, input int b);
        chk_eq({tag, "_r"}, 32'(lf[i][0]), 32'(r));
        chk_eq({tag, "_g"}, 32'(lf[i][1]), 32'(g));
        chk_eq({tag, "_b"}, 32'(lf[i][2]), 32'(b));
    endtask

    function automatic logic [7:0] rnd_chan();
        int sel;
        sel = int'($urandom_range(0, 3));
        if (sel == 0) return 8'h00;
        if (sel == 1) return 8'hFF;
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        rst    = 1'b0;
        enable = 1'b0;
        load   = 1'b0;
        colour = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_eq("reset_outs_p1", 32'(o0), 32'h0);
        chk_eq("reset_outs_p4", 32'(o1), 32'h0);
        rst = 1'b1;

        // mid-frame asynchronous reset with active = 808080
        step(1'b1, 1'b1, 24'h808080);
        idle(650);
        #2 rst = 1'b0;
        #1;
        chk_eq("arst_outs_p1", 32'(o0), 32'h0);
        chk_eq("arst_outs_p4", 32'(o1), 32'h0);
        chk_eq("arst_cnt_p1", 32'(dut0.cnt), 32'h0);
        chk_eq("arst_active_p1", 32'(dut0.active), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        idle(20);

        // blue load at cnt = 10
        for (int k = 0; k < 600 && mcnt(0) != 10; k++) idle(1);
        step(1'b1, 1'b1, 24'h0000FF);
        chk_eq("blue_pending", 32'(o0[0]), 32'h1);
        idle(2100);
        chk_frame("blue_p1", 0, 0, 0, 255);
        chk_frame("blue_p4", 1, 0, 0, 1020);

        // mixed duty
        step(1'b1, 1'b1, 24'h804000);
        idle(2100);
        chk_frame("mix_p1", 0, 128, 64, 0);
        chk_frame("mix_p4", 1, 512, 256, 0);

        // double load, the last one wins
        step(1'b1, 1'b1, 24'hFF0000);
        idle(3);
        step(1'b1, 1'b1, 24'h00FF00);
        idle(2100);
        chk_frame("dbl_p1", 0, 0, 255, 0);
        chk_frame("dbl_p4", 1, 0, 1020, 0);

        // load coincident with wrap on the PRESCALE=1 instance
        for (int k = 0; k < 600 && mcnt(0) != 255; k++) idle(1);
        step(1'b1, 1'b1, 24'hFFFFFF);
        chk_eq("wrapload_pending", 32'(o0[0]), 32'h0);
        chk_eq("wrapload_fs", 32'(o0[1]), 32'h1);
        idle(300);
        chk_frame("wrapload_p1", 0, 255, 255, 255);

        // enable pause at cnt = 100 with a load during the pause
        for (int k = 0; k < 600 && mcnt(0) != 100; k++) idle(1);
        for (int k = 0; k < 20; k++) begin
            step(1'b0, (k == 5), 24'h123456);
            if (k == 0) chk_eq("pause_pwm_low", 32'(o0[4:2]), 32'h0);
        end
        chk_eq("pause_cnt_hold", 32'(dut0.cnt), 32'd100);
        chk_eq("pause_pending", 32'(o0[0]), 32'h1);
        idle(600);
        chk_frame("resume_p1", 0, 8'h12, 8'h34, 8'h56);

        // randomized phase
        for (int k = 0; k < 8000; k++) begin
            step(($urandom_range(0, 19) != 0), ($urandom_range(0, 149) == 0),
                 {rnd_chan(), rnd_chan(), rnd_chan()});
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
